byte_decode: RTL and testbench



---
 rtl/byte_decode.sv | 194 +++++++++++++++++++
 tb/tb_byte_decode.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/byte_decode.sv
// ---------------------------------------------------------------------------
// byte_decode
//
// ByteDecode_l unit for Kyber polynomials. One encoded polynomial of
// 32*l bytes arrives as 4*l 64-bit words. It leaves as 64 beats of four
// 16-bit coefficients, where each coefficient is l bits wide.
//
// Build option:
//   BYTE_DECODE_MODQ_EN  When defined, l = 12 coefficients are reduced
//                        mod 3329 with a single conditional subtraction.
//                        When undefined, l = 12 coefficients pass through
//                        raw (0..4095).
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst           asynchronous reset, active-high
//   i_ibytes        input word; stream byte k is [63-8k -: 8]
//   i_ibytes_valid  input word valid
//   o_ibytes_ready  word can be accepted this cycle (depends only on
//                   registered state)
//   i_l             bits per coefficient; latched on the first word of a
//                   polynomial; 0 and 13..15 select 12
//   o_coeffs        four coefficients; lane 0 in [63:48], lane 3 in [15:0]
//   o_coeffs_valid  one-cycle beat qualifier
//   o_done          one-cycle pulse, one cycle after the 64th beat
//
// States:
//   IDLE | waiting for the first word of a polynomial
//   RUN  | accepting words and extracting beats
//   DONE | all 64 beats emitted; o_done high; input refused
// ---------------------------------------------------------------------------
module byte_decode (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_ibytes,
    input  logic        i_ibytes_valid,
    output logic        o_ibytes_ready,
    input  logic [3:0]  i_l,
    output logic [63:0] o_coeffs,
    output logic        o_coeffs_valid,
    output logic        o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [127:0] bit_buf;
    logic [127:0] bit_buf_nxt;
    logic [7:0]   fill;
    logic [7:0]   fill_nxt;
    logic [7:0]   fill_rem;
    logic [5:0]   words;
    logic [5:0]   words_nxt;
    logic [6:0]   beats;
    logic [6:0]   beats_nxt;
    logic [3:0]   l_reg;
    logic [3:0]   l_nxt;
    logic [5:0]   beat_bits;
    logic [63:0]  stream_word;
    logic [63:0]  coeffs_nxt;
    logic         accept;
    logic         extract;

    function automatic logic [3:0] l_decode(input logic [3:0] l_in);
        if (l_in == 4'd0 || l_in > 4'd12) begin
            return 4'd12;
        end
        return l_in;
    endfunction

    // Reverse the byte order so that stream bit n sits at bit n of the word.
    // Bits inside a byte are already LSB-first.
    always_comb begin
        stream_word = '0;
        for (int k = 0; k < 8; k++) begin
            stream_word[8*k +: 8] = i_ibytes[63-8*k -: 8];
        end
    end

    assign beat_bits = {l_reg, 2'b00};
    assign extract   = (state == S_RUN) && (fill >= {2'b00, beat_bits});
    assign fill_rem  = fill - (extract ? {2'b00, beat_bits} : 8'd0);
    assign accept    = i_ibytes_valid && o_ibytes_ready;

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    // RUN leaves one cycle after the last extraction, once the beat counter
    // shows 64. This places DONE (and o_done) one cycle after the final beat.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_RUN;
            S_RUN:  if (beats == 7'd64) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output / datapath next-value logic ----------------
    // The words counter runs up to 4*l, which equals beat_bits numerically.
    // A word is taken only if the buffer, after this cycle's extraction,
    // still has 64 free bits.
    always_comb begin
        o_ibytes_ready = (state == S_IDLE) ||
                         ((state == S_RUN) && (words < beat_bits) && (fill_rem <= 8'd64));
    end

    always_comb begin
        bit_buf_nxt = extract ? (bit_buf >> beat_bits) : bit_buf;
        fill_nxt    = fill_rem;
        words_nxt   = words;
        beats_nxt   = extract ? beats + 7'd1 : beats;
        l_nxt       = l_reg;
        if (accept) begin
            if (state == S_IDLE) begin
                bit_buf_nxt = {64'd0, stream_word};
                fill_nxt    = 8'd64;
                words_nxt   = 6'd1;
                beats_nxt   = 7'd0;
                l_nxt       = l_decode(i_l);
            end else begin
                bit_buf_nxt = bit_buf_nxt | ({64'd0, stream_word} << fill_rem);
                fill_nxt    = fill_rem + 8'd64;
                words_nxt   = words + 6'd1;
            end
        end
    end

    // Lane c starts at bit c*l of the lowest 4*l buffer bits.
    always_comb begin
        logic [5:0]  lane_sh [4];
        logic [12:0] mask;
        logic [47:0] chunk_sh;
        logic [11:0] raw;
        lane_sh[0] = 6'd0;
        lane_sh[1] = {2'b00, l_reg};
        lane_sh[2] = {1'b0, l_reg, 1'b0};
        lane_sh[3] = lane_sh[1] + lane_sh[2];
        mask       = (13'd1 << l_reg) - 13'd1;
        coeffs_nxt = '0;
        chunk_sh   = '0;
        raw        = '0;
        for (int c = 0; c < 4; c++) begin
            chunk_sh = bit_buf[47:0] >> lane_sh[c];
            raw      = chunk_sh[11:0] & mask[11:0];
`ifdef BYTE_DECODE_MODQ_EN
            if (l_reg == 4'd12 && raw >= 12'd3329) begin
                raw = raw - 12'd3329;
            end
`endif
            coeffs_nxt[63-16*c -: 16] = {4'd0, raw};
        end
    end

    // ---------------- datapath and registered outputs ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bit_buf        <= '0;
            fill           <= '0;
            words          <= '0;
            beats          <= '0;
            l_reg          <= 4'd12;
            o_coeffs       <= '0;
            o_coeffs_valid <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            bit_buf        <= bit_buf_nxt;
            fill           <= fill_nxt;
            words          <= words_nxt;
            beats          <= beats_nxt;
            l_reg          <= l_nxt;
            o_coeffs_valid <= extract;
            o_done         <= (state == S_RUN) && (state_nxt == S_DONE);
            if (extract) begin
                o_coeffs <= coeffs_nxt;
            end
        end
    end

endmodule

// File: tb/tb_byte_decode.sv
module tb_byte_decode;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [63:0] i_ibytes;
    logic        i_ibytes_valid;
    logic        o_ibytes_ready;
    logic [3:0]  i_l;
    logic [63:0] o_coeffs;
    logic        o_coeffs_valid;
    logic        o_done;

    int checks = 0;
    int failures = 0;

    logic [63:0] wmem    [0:47];
    logic [63:0] rcv     [0:63];
    logic [63:0] ref_rcv [0:63];

    byte_decode dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_ibytes       (i_ibytes),
        .i_ibytes_valid (i_ibytes_valid),
        .o_ibytes_ready (o_ibytes_ready),
        .i_l            (i_l),
        .o_coeffs       (o_coeffs),
        .o_coeffs_valid (o_coeffs_valid),
        .o_done         (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: stream bit n is bit (n%8) of byte (n/8).
    function automatic logic [15:0] ref_coef(input int i, input int lv);
        int v;
        int n;
        logic [63:0] w;
        v = 0;
        for (int j = 0; j < lv; j++) begin
            n = i * lv + j;
            w = wmem[n / 64];
            if (w[56 - 8 * ((n % 64) / 8) + (n % 8)]) v = v + (1 << j);
        end
`ifdef BYTE_DECODE_MODQ_EN
        if (lv == 12 && v >= 3329) v = v - 3329;
`endif
        return 16'(v);
    endfunction

    function automatic logic [63:0] ref_beat(input int b, input int lv);
        return {ref_coef(4*b, lv), ref_coef(4*b+1, lv), ref_coef(4*b+2, lv), ref_coef(4*b+3, lv)};
    endfunction

    // Drives one polynomial and keeps offering extra words until o_done.
    // Stops early once abort_at beats were seen (abort_at > 0).
    task automatic run_poly(input int lv, input logic [3:0] lpin, input int nwords,
                            input bit gap, input int abort_at);
        int acc, nb, cyc, fill, rem, bb;
        bit started, done_seen, phase, will, exp_rdy;
        acc = 0; nb = 0; cyc = 0; bb = 4 * lv;
        started = 0; done_seen = 0; phase = 1;
        i_l = lpin;
        @(negedge i_clk);
        while (1) begin
            if (o_coeffs_valid) begin
                if (nb < 64) begin
                    check($sformatf("beat%0d", nb), o_coeffs, ref_beat(nb, lv));
                    rcv[nb] = o_coeffs;
                end
                nb++;
            end
            if (o_done) begin
                check("done_after_64_beats", 64'(nb), 64'd64);
                check("done_not_with_valid", {63'd0, o_coeffs_valid}, 64'd0);
                done_seen = 1;
            end
            if (abort_at > 0 && nb >= abort_at) break;
            fill = 64 * acc - bb * nb;
            rem  = (started && fill >= bb) ? fill - bb : fill;
            exp_rdy = !started ? 1'b1 : (done_seen ? 1'b0 : (acc < nwords && rem <= 64));
            check("ready", {63'd0, o_ibytes_ready}, {63'd0, exp_rdy});
            if (done_seen) break;
            i_ibytes_valid = gap ? phase : 1'b1;
            phase = !phase;
            i_ibytes = (acc < nwords) ? wmem[acc] : 64'hBAD0_BAD0_BAD0_BAD0;
            #1;
            will = i_ibytes_valid && o_ibytes_ready;
            @(posedge i_clk);
            if (will) begin
                acc++;
                started = 1;
            end
            cyc++;
            if (cyc > 3000) begin
                check("timeout", 64'(cyc), 64'd0);
                break;
            end
            @(negedge i_clk);
        end
        i_ibytes_valid = 1'b0;
        if (abort_at == 0) check("words_accepted", 64'(acc), 64'(nwords));
    endtask

    initial begin
        i_rst = 1'b1;
        i_ibytes = '0;
        i_ibytes_valid = 1'b0;
        i_l = 4'd1;
        #1;
        check("rst_coeffs", o_coeffs, 64'd0);
        check("rst_valid", {63'd0, o_coeffs_valid}, 64'd0);
        check("rst_done", {63'd0, o_done}, 64'd0);
        check("rst_ready", {63'd0, o_ibytes_ready}, 64'd1);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        // l=1, all ones
        for (int i = 0; i < 48; i++) wmem[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_poly(1, 4'd1, 4, 0, 0);
        check("l1_beat0", rcv[0], 64'h0001_0001_0001_0001);
        check("l1_beat63", rcv[63], 64'h0001_0001_0001_0001);

        // l=4 ordering
        wmem[0] = 64'h2143_6587_A9CB_ED0F;
        for (int i = 1; i < 48; i++) wmem[i] = 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h1111_0000_0101_0303);
        run_poly(4, 4'd4, 16, 0, 0);
        check("l4_beat0", rcv[0], 64'h0001_0002_0003_0004);
        check("l4_beat1", rcv[1], 64'h0005_0006_0007_0008);

        // l=12 all 0xFF, selected with i_l=0
        for (int i = 0; i < 48; i++) wmem[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_poly(12, 4'd0, 48, 0, 0);
`ifdef BYTE_DECODE_MODQ_EN
        check("l12_ff_beat0", rcv[0], 64'h02FE_02FE_02FE_02FE);
        check("l12_ff_beat63", rcv[63], 64'h02FE_02FE_02FE_02FE);
`else
        check("l12_ff_beat0", rcv[0], 64'h0FFF_0FFF_0FFF_0FFF);
        check("l12_ff_beat63", rcv[63], 64'h0FFF_0FFF_0FFF_0FFF);
`endif

        // l=12 boundary: 3328, 3329, 0, 0
        for (int i = 0; i < 48; i++) wmem[i] = 64'd0;
        wmem[0] = 64'h001D_D000_0000_0000;
        run_poly(12, 4'd12, 48, 0, 0);
`ifdef BYTE_DECODE_MODQ_EN
        check("l12_bound_beat0", rcv[0], 64'h0D00_0000_0000_0000);
`else
        check("l12_bound_beat0", rcv[0], 64'h0D00_0D01_0000_0000);
`endif
        check("l12_bound_beat1", rcv[1], 64'd0);

        // l=10 gap-free, then with valid toggling
        for (int i = 0; i < 48; i++) wmem[i] = 64'h9E37_79B9_7F4A_7C15 * 64'(i + 3);
        run_poly(10, 4'd10, 40, 0, 0);
        for (int i = 0; i < 64; i++) ref_rcv[i] = rcv[i];
        run_poly(10, 4'd10, 40, 1, 0);
        for (int i = 0; i < 64; i++) check($sformatf("gap_same_beat%0d", i), rcv[i], ref_rcv[i]);

        // reset after beat 20 of an l=10 polynomial
        run_poly(10, 4'd10, 40, 0, 21);
        i_rst = 1'b1;
        #1;
        check("mid_rst_coeffs", o_coeffs, 64'd0);
        check("mid_rst_valid", {63'd0, o_coeffs_valid}, 64'd0);
        check("mid_rst_done", {63'd0, o_done}, 64'd0);
        check("mid_rst_ready", {63'd0, o_ibytes_ready}, 64'd1);
        @(negedge i_clk);
        i_rst = 1'b0;

        // fresh l=5 polynomial
        for (int i = 0; i < 48; i++) wmem[i] = 64'hC3A5_0F96_5AF0_1E2D ^ (64'(i) << 7);
        run_poly(5, 4'd5, 20, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
